// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake plus instruction-memory write port of the program loader.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  // master: stream source / memory sink; slave: the loader itself
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: length-prefixed big-endian byte stream -> consecutive instruction memory words,
// holding the core in stall until the load completes.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN   = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

  logic [2:0]          state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         len_q, len_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_WIDTH:0] index_q, index_d, index_inc;
  logic                error_q, error_d;

  logic        xfer;
  logic        last_byte;
  logic [31:0] shift_len;
  logic [31:0] shift_word;

  assign xfer       = bus.rx_valid && bus.rx_ready;
  assign last_byte  = xfer && (byte_cnt_q == 2'd3);
  assign shift_len  = {len_q[23:0], bus.rx_data};
  assign shift_word = {word_q[23:0], bus.rx_data};
  assign index_inc  = index_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    index_d    = index_q;
    error_d    = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LEN;
          byte_cnt_d = 2'd0;
          index_d    = '0;
          error_d    = 1'b0;
        end
      end
      LEN: begin
        if (xfer) begin
          len_d      = shift_len;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            if (shift_len == 32'd0) begin
              state_d = FIN;
            end else if ({1'b0, shift_len} > CAPACITY) begin
              error_d = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (xfer) begin
          word_d     = shift_word;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        index_d = index_inc;
        // len_q never exceeds the capacity here, so its low ADDR_WIDTH+1 bits hold all of N
        state_d = (index_inc == len_q[ADDR_WIDTH:0]) ? FIN : DATA;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      len_q      <= 32'd0;
      word_q     <= 32'd0;
      index_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      index_q    <= index_d;
      error_q    <= error_d;
    end
  end

  assign bus.rx_ready   = (state_q == LEN) || (state_q == DATA);
  assign bus.imem_we    = (state_q == WRITE);
  assign bus.imem_addr  = BASE_ADDR + (32'(index_q) << 2);
  assign bus.imem_wdata = word_q;
  assign cpu_hold       = (state_q != IDLE);
  assign done           = (state_q == FIN);
  assign error          = error_q;
  assign words_loaded   = index_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory before the MIPS core runs. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It drives the instruction memory write port at consecutive word addresses and holds the core in stall until the load finishes. It is the write-side counterpart of the instruction memory's PC-indexed read port.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-address width; capacity is 2^ADDR_WIDTH words
- BASE_ADDR, 32'h0000_0000, byte address of the first written word (word-aligned)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a load; honoured only in IDLE
- rx_data  input  8  stream byte
- rx_valid  input  1  rx_data is valid
- rx_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  instruction memory write enable
- imem_addr  output  32  byte address of the write (BASE_ADDR + 4*index)
- imem_wdata  output  32  instruction word being written
- cpu_hold  output  1  stall request to the core; high whenever not IDLE
- done  output  1  one-cycle pulse when the load completes
- error  output  1  sticky length-overflow flag
- words_loaded  output  ADDR_WIDTH+1  number of words written in the current or last load

## Operation
- States: IDLE, LEN, DATA, WRITE, FIN.
- Byte transfer occurs when rx_valid && rx_ready.
  - rx_ready = 1 only in LEN and DATA.
- IDLE:
  - When start = 1, clear error and words_loaded, clear the byte counter, and go to LEN.
- LEN:
  - Collect 4 bytes, MSB first, into count N (32 bits).
  - When the 4th byte is accepted:
    - if N == 0, go to FIN;
    - if N > 2^ADDR_WIDTH, set error and go to IDLE (no writes);
    - otherwise go to DATA.
- DATA:
  - Collect 4 bytes MSB first into a word register.
  - When the 4th byte is accepted, go to WRITE.
- WRITE:
  - Drive imem_we = 1 for exactly one cycle, with imem_addr = BASE_ADDR + (index << 2) and imem_wdata = the assembled word.
  - Increment index and words_loaded.
  - If the new index == N, go to FIN; otherwise go to DATA.
- FIN:
  - done = 1 for one cycle, then go to IDLE.
- start in any state other than IDLE is ignored.
- The byte counter wraps 3 -> 0 within each 4-byte field.
- index never exceeds N. imem_addr is computed modulo 2^32.
- imem_addr and imem_wdata are don't-care when imem_we = 0; the bench checks them only when imem_we = 1.

## Timing
- Reset values (asynchronous):
  - state = IDLE
  - rx_ready, imem_we, cpu_hold, done, error = 0
  - words_loaded = 0
  - imem_addr = BASE_ADDR
  - imem_wdata = 0
- start sampled high in cycle t: rx_ready and cpu_hold are high from cycle t+1.
- 4th data byte accepted in cycle k: imem_we is high in cycle k+1, and rx_ready is low in cycle k+1.
- rx_ready returns high in cycle k+2, or done is high in k+2 if that was the last word.
- Peak throughput is 5 cycles per word with rx_valid held high. Gaps in rx_valid only stretch LEN/DATA; no state is lost.
- cpu_hold falls in the cycle after done. done and cpu_hold are never both high with state IDLE.
- reset_n asserted mid-load: all outputs return to reset values immediately.
  - Words already written stay in memory.
  - A new start is required to reload.
- error asserts in the cycle after the 4th length byte and holds until the next accepted start.

## Test plan
- Reset and idle, no start, rx_valid = 1:
  - required: rx_ready = 0, imem_we = 0, cpu_hold = 0, done = 0, error = 0, imem_addr = 0 throughout.
- Two-word load, contiguous bytes 00 00 00 02 | 20 08 00 01 | 21 09 00 02, BASE_ADDR = 0:
  - required: write 0x20080001 @ 0x00000000, then 0x21090002 @ 0x00000004;
  - done pulse one cycle after the 2nd write; words_loaded = 2; cpu_hold low afterwards.
- Zero length, bytes 00 00 00 00:
  - required: no imem_we, done pulse, words_loaded = 0.
- Overflow with ADDR_WIDTH = 8, length 00 00 01 01 (257):
  - required: error = 1, no writes, returns to IDLE.
  - A subsequent start clears error; a valid 1-word load then succeeds.
- rx_valid toggling every other cycle plus start pulses during the load:
  - required: same writes as the contiguous case, start ignored, each imem_we exactly one cycle.
- reset_n pulsed low after the 2nd data byte of word 1:
  - required: immediate reset values, no write of the partial word;
  - a fresh start followed by the full stream loads correctly from BASE_ADDR.
